// File: rtl/video_tpg_pkg.sv
// Shared types and helpers for the multi-pixel video test pattern generator.
package video_tpg_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    // Bar colours, each entry is a {R,G,B} full-scale flag set; index 0 is the left-most bar.
    localparam logic [7:0][2:0] BAR_TBL = {
        3'b000,   // 7 black
        3'b001,   // 6 blue
        3'b100,   // 5 red
        3'b101,   // 4 magenta
        3'b010,   // 3 green
        3'b011,   // 2 cyan
        3'b110,   // 1 yellow
        3'b111    // 0 white
    };

    // Pack one pixel as {R,B,G}; the result occupies the low 3*bpc bits.
    function automatic logic [29:0] pack_rbg(input logic [9:0] r, input logic [9:0] g,
                                             input logic [9:0] b, input int bpc);
        return (30'(r) << (2 * bpc)) | (30'(b) << bpc) | 30'(g);
    endfunction

endpackage

// File: rtl/video_tpg_mp_pix.sv
// Single-pixel generator: pattern lookup for one pixel position, registered on load.
// With VIDEO_TPG_MP_MOTION_EN defined the pattern scrolls with the frame counter.
module video_tpg_pix
    import video_tpg_pkg::*;
#(
    parameter int BPC      = 8,
    parameter int H_ACTIVE = 1920,
    parameter int XW       = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_i,
    input  logic [XW-1:0]      px_i,
    input  logic               y5_i,
    input  pat_e               pat_i,
    input  logic [3*BPC-1:0]   solid_i,
`ifdef VIDEO_TPG_MP_MOTION_EN
    input  logic [XW-1:0]      xoff_i,
    input  logic [BPC-1:0]     fcnt_i,
`endif
    output logic [3*BPC-1:0]   pix_o
);

    localparam int PW    = 3 * BPC;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [9:0] FULL = 10'((1 << BPC) - 1);

    logic [XW-1:0]  pxs;
    logic [BPC-1:0] ramp;
    logic [2:0]     bar;
    logic [2:0]     rgb;
    logic [PW-1:0]  pix_d;
    logic [PW-1:0]  pix_q;

    // Pattern lookup; bar index by threshold compares so no divider is needed.
    always_comb begin
        pxs = px_i;
`ifdef VIDEO_TPG_MP_MOTION_EN
        pxs = px_i + xoff_i;
        if (pxs >= XW'(H_ACTIVE)) pxs = pxs - XW'(H_ACTIVE);
`endif
        ramp = BPC'(px_i);
`ifdef VIDEO_TPG_MP_MOTION_EN
        ramp = ramp + fcnt_i;
`endif
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (pxs >= XW'(k * BAR_W)) bar = 3'(k);
        end
        rgb = BAR_TBL[bar];
        case (pat_i)
            PAT_BARS:  pix_d = PW'(pack_rbg(rgb[2] ? FULL : 10'd0, rgb[1] ? FULL : 10'd0,
                                            rgb[0] ? FULL : 10'd0, BPC));
            PAT_RAMP:  pix_d = PW'(pack_rbg(10'(ramp), 10'(ramp), 10'(ramp), BPC));
            PAT_CHECK: pix_d = (pxs[5] ^ y5_i) ? '1 : '0;
            default:   pix_d = solid_i;
        endcase
    end

    // Output pixel register, updated whenever the top loads a new beat.
    always_ff @(posedge clk) begin
        if (!rst)      pix_q <= '0;
        else if (ld_i) pix_q <= pix_d;
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/video_tpg_mp.sv
// AXI4-Stream video test pattern generator, PPC pixels per beat.
// Optional scrolling patterns: define VIDEO_TPG_MP_MOTION_EN.
module video_tpg_mp
    import video_tpg_pkg::*;
#(
    parameter int PPC      = 1,
    parameter int BPC      = 8,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int FCNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                pattern_sel,
    input  logic [3*BPC-1:0]          solid_rgb,
    output logic [PPC*3*BPC-1:0]      m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tuser,
    output logic                      m_axis_tlast,
    output logic [PPC*3*BPC/8-1:0]    m_axis_tkeep,
    output logic [FCNT_W-1:0]         frame_cnt,
    output logic                      busy
);

    localparam int PW = 3 * BPC;
    // x holds one extra bit for the scrolled position, and both counters reach bit 5 for the checkerboard.
    localparam int XW = ($clog2(H_ACTIVE) + 1 > 6) ? $clog2(H_ACTIVE) + 1 : 6;
    localparam int YW = ($clog2(V_ACTIVE) > 6) ? $clog2(V_ACTIVE) : 6;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    pat_e              pat_q, pat_d;
    logic [PW-1:0]     solid_q, solid_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              vld_q, vld_d, user_q, user_d, last_q, last_d;
    logic              load;
    logic              line_end, frame_end;
    logic [PPC-1:0][PW-1:0] tdata_w;
`ifdef VIDEO_TPG_MP_MOTION_EN
    logic [XW-1:0]     off_q, off_d;
`endif

    assign line_end  = (x_q == XW'(H_ACTIVE - PPC));
    assign frame_end = line_end && (y_q == YW'(V_ACTIVE - 1));

    // Next-state: frame start/continue, beat advance on transfer, pattern relatch at frame boundary.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        fcnt_d  = fcnt_q;
        vld_d   = vld_q;
        user_d  = user_q;
        last_d  = last_q;
        load    = 1'b0;
`ifdef VIDEO_TPG_MP_MOTION_EN
        off_d   = off_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    pat_d   = pat_e'(pattern_sel);
                    solid_d = solid_rgb;
                    vld_d   = 1'b1;
                    user_d  = 1'b1;
                    last_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            default: begin
                if (m_axis_tready) begin
                    if (frame_end) begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
`ifdef VIDEO_TPG_MP_MOTION_EN
                        if (fcnt_q[7:0] == 8'hFF)                     off_d = '0;
                        else if (off_q + XW'(PPC) >= XW'(H_ACTIVE)) off_d = off_q + XW'(PPC) - XW'(H_ACTIVE);
                        else                                         off_d = off_q + XW'(PPC);
`endif
                        x_d = '0;
                        y_d = '0;
                        if (en) begin
                            pat_d   = pat_e'(pattern_sel);
                            solid_d = solid_rgb;
                            user_d  = 1'b1;
                            last_d  = 1'b0;
                            load    = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            vld_d   = 1'b0;
                            user_d  = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        load   = 1'b1;
                        user_d = 1'b0;
                        if (line_end) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(PPC);
                        end
                        last_d = (x_d == XW'(H_ACTIVE - PPC));
                    end
                end
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= PAT_BARS;
            solid_q <= '0;
            fcnt_q  <= '0;
            vld_q   <= 1'b0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef VIDEO_TPG_MP_MOTION_EN
            off_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            fcnt_q  <= fcnt_d;
            vld_q   <= vld_d;
            user_q  <= user_d;
            last_q  <= last_d;
`ifdef VIDEO_TPG_MP_MOTION_EN
            off_q   <= off_d;
`endif
        end
    end

    // One generator per pixel lane; each sees the next beat's coordinates.
    for (genvar p = 0; p < PPC; p++) begin : g_pix
        video_tpg_pix #(.BPC(BPC), .H_ACTIVE(H_ACTIVE), .XW(XW)) u_pix (
            .clk     (clk),
            .rst     (rst),
            .ld_i    (load),
            .px_i    (x_d + XW'(p)),
            .y5_i    (y_d[5]),
            .pat_i   (pat_d),
            .solid_i (solid_d),
`ifdef VIDEO_TPG_MP_MOTION_EN
            .xoff_i  (off_d),
            .fcnt_i  (fcnt_d[BPC-1:0]),
`endif
            .pix_o   (tdata_w[p])
        );
    end

    assign m_axis_tdata  = tdata_w;
    assign m_axis_tvalid = vld_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tkeep  = '1;
    assign frame_cnt     = fcnt_q;
    assign busy          = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_video_tpg_mp.sv
// Directed bench for video_tpg_mp: 16x4 frame, 2 pixels per beat, 8 bits per component.
module tb_video_tpg_mp;

    localparam int PPC = 2, BPC = 8, H = 16, V = 4, FW = 16;
    localparam int BEATS = (H / PPC) * V;

    logic              clk = 1'b0;
    logic              rst, en, tready;
    logic [1:0]        pattern_sel;
    logic [23:0]       solid_rgb;
    logic [47:0]       m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy;
    logic [5:0]        m_axis_tkeep;
    logic [FW-1:0]     frame_cnt;

    int n_chk = 0;
    int n_fail = 0;

    video_tpg_mp #(.PPC(PPC), .BPC(BPC), .H_ACTIVE(H), .V_ACTIVE(V), .FCNT_W(FW)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pattern_sel   (pattern_sel),
        .solid_rgb     (solid_rgb),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .frame_cnt     (frame_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference pixel, packed {R,B,G}.
    function automatic logic [23:0] exp_pix(int pat, int px, int y, logic [23:0] solid);
        case (pat)
            0: case (px / 2)
                   0: return 24'hFFFFFF;  // white
                   1: return 24'hFF00FF;  // yellow  R,G
                   2: return 24'h00FFFF;  // cyan    B,G
                   3: return 24'h0000FF;  // green
                   4: return 24'hFFFF00;  // magenta R,B
                   5: return 24'hFF0000;  // red
                   6: return 24'h00FF00;  // blue
                   default: return 24'h000000;
               endcase
            1: return {3{8'(px)}};
            2: return ((((px >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return solid;
        endcase
    endfunction

    function automatic logic [47:0] exp_beat(int pat, int b, logic [23:0] solid);
        int x, y;
        x = (b % (H / PPC)) * PPC;
        y = b / (H / PPC);
        return {exp_pix(pat, x + 1, y, solid), exp_pix(pat, x, y, solid)};
    endfunction

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; tready = 1'b1; pattern_sel = 2'd0; solid_rgb = 24'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        n_chk++; if (m_axis_tuser !== 1'b0 || m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_user_last got %b%b want 00", m_axis_tuser, m_axis_tlast); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_fcnt got %0d want 0", frame_cnt); end
        n_chk++; if (m_axis_tdata !== 48'h0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        n_chk++; if (m_axis_tkeep !== 6'h3F) begin n_fail++; $display("FAIL tkeep got %h want 3f", m_axis_tkeep); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL idle_no_en got tvalid %b want 0", m_axis_tvalid); end
    endtask

    // Colour bars at full rate, en dropped right after the frame starts.
    task automatic test_bars();
        pattern_sel = 2'd0; tready = 1'b1; en = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            en = 1'b0;
            n_chk++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL bars_valid beat %0d got %b want 1", b, m_axis_tvalid); end
            n_chk++; if (m_axis_tdata !== exp_beat(0, b, 24'h0)) begin n_fail++; $display("FAIL bars_data beat %0d got %h want %h", b, m_axis_tdata, exp_beat(0, b, 24'h0)); end
            n_chk++; if (m_axis_tuser !== (b == 0)) begin n_fail++; $display("FAIL bars_tuser beat %0d got %b", b, m_axis_tuser); end
            n_chk++; if (m_axis_tlast !== (b % 8 == 7)) begin n_fail++; $display("FAIL bars_tlast beat %0d got %b", b, m_axis_tlast); end
            n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bars_busy beat %0d got %b want 1", b, busy); end
        end
        @(negedge clk);
        n_chk++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL bars_fcnt got %0d want 1", frame_cnt); end
        n_chk++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bars_idle got tvalid %b busy %b want 0 0", m_axis_tvalid, busy); end
    endtask

    // Ramp with tready alternating: each beat is held across a stall cycle then accepted.
    task automatic test_ramp_stall();
        pattern_sel = 2'd1; tready = 1'b0; en = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            en = 1'b0;
            n_chk++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_beat(1, b, 24'h0)) begin n_fail++; $display("FAIL ramp_data beat %0d got v%b %h want %h", b, m_axis_tvalid, m_axis_tdata, exp_beat(1, b, 24'h0)); end
            tready = 1'b0;
            @(negedge clk);
            n_chk++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_beat(1, b, 24'h0)) begin n_fail++; $display("FAIL ramp_stall_data beat %0d got v%b %h want %h", b, m_axis_tvalid, m_axis_tdata, exp_beat(1, b, 24'h0)); end
            n_chk++; if (m_axis_tuser !== (b == 0) || m_axis_tlast !== (b % 8 == 7)) begin n_fail++; $display("FAIL ramp_stall_flags beat %0d got user %b last %b", b, m_axis_tuser, m_axis_tlast); end
            tready = 1'b1;
        end
        @(negedge clk);
        n_chk++; if (frame_cnt !== 16'd2 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL ramp_end got fcnt %0d tvalid %b want 2 0", frame_cnt, m_axis_tvalid); end
    endtask

    // One-cycle en pulse gives exactly one frame.
    task automatic test_en_pulse();
        int  beats = 0;
        bit  done = 0;
        pattern_sel = 2'd2; tready = 1'b1;
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (m_axis_tvalid === 1'b1) begin
                if (beats < BEATS && m_axis_tdata !== exp_beat(2, beats, 24'h0)) begin
                    n_chk++; n_fail++; $display("FAIL check_data beat %0d got %h want %h", beats, m_axis_tdata, exp_beat(2, beats, 24'h0));
                end
                beats++;
                @(negedge clk);
            end else done = 1;
        end
        n_chk++; if (!done) begin n_fail++; $display("FAIL pulse_timeout got still valid after 100 cycles want idle"); end
        n_chk++; if (beats != BEATS) begin n_fail++; $display("FAIL pulse_beats got %0d want %0d", beats, BEATS); end
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL pulse_idle got busy %b tvalid %b want 0 0", busy, m_axis_tvalid); end
        n_chk++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL pulse_fcnt got %0d want 3", frame_cnt); end
    endtask

    // pattern_sel changed mid-frame is only picked up at the next frame, back to back.
    task automatic test_back_to_back();
        pattern_sel = 2'd0; solid_rgb = 24'h123456; tready = 1'b1; en = 1'b1;
        for (int b = 0; b < 2 * BEATS; b++) begin
            @(negedge clk);
            if (b == 5) pattern_sel = 2'd3;
            if (b == BEATS) en = 1'b0;
            n_chk++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_beat(b < BEATS ? 0 : 3, b % BEATS, 24'h123456)
                || m_axis_tuser !== (b % BEATS == 0)) begin
                n_fail++; $display("FAIL b2b beat %0d got v%b u%b %h want %h", b, m_axis_tvalid, m_axis_tuser, m_axis_tdata, exp_beat(b < BEATS ? 0 : 3, b % BEATS, 24'h123456));
            end
        end
        @(negedge clk);
        n_chk++; if (frame_cnt !== 16'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end got fcnt %0d busy %b want 5 0", frame_cnt, busy); end
        pattern_sel = 2'd0;
    endtask

    // Reset at beat 10 aborts the frame; restart begins at x=0, y=0.
    task automatic test_reset_mid();
        pattern_sel = 2'd0; tready = 1'b1; en = 1'b1;
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            en = 1'b0;
        end
        @(negedge clk);
        n_chk++; if (m_axis_tdata !== exp_beat(0, 10, 24'h0)) begin n_fail++; $display("FAIL pre_reset_beat10 got %h want %h", m_axis_tdata, exp_beat(0, 10, 24'h0)); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_chk++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got v%b l%b busy%b want 000", m_axis_tvalid, m_axis_tlast, busy); end
        n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_fcnt got %0d want 0", frame_cnt); end
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n_chk++; if (m_axis_tvalid !== 1'b1 || m_axis_tuser !== 1'b1 || m_axis_tdata !== 48'hFFFFFF_FFFFFF) begin n_fail++; $display("FAIL restart_beat0 got v%b u%b %h want 1 1 ffffffffffff", m_axis_tvalid, m_axis_tuser, m_axis_tdata); end
        @(negedge clk);
        n_chk++; if (m_axis_tuser !== 1'b0 || m_axis_tdata !== exp_beat(0, 1, 24'h0)) begin n_fail++; $display("FAIL restart_beat1 got u%b %h want 0 %h", m_axis_tuser, m_axis_tdata, exp_beat(0, 1, 24'h0)); end
        repeat (BEATS) @(negedge clk);
        n_chk++; if (frame_cnt !== 16'd1 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL restart_end got fcnt %0d tvalid %b want 1 0", frame_cnt, m_axis_tvalid); end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_ramp_stall();
        test_en_pulse();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
